// File: rtl/demux3_buffered.sv
// Buffered 1-to-3 demultiplexer: accepted words queue in an in-order FIFO and
// each head word is offered to exactly one of three consumers via valid/ready.
module demux3_buffered #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       select_in,
   input  logic [W-1:0]     entrada,
   output logic             valid0,
   output logic             valid1,
   output logic             valid2,
   input  logic             ready0,
   input  logic             ready1,
   input  logic             ready2,
   output logic [W-1:0]     saida0,
   output logic [W-1:0]     saida1,
   output logic [W-1:0]     saida2,
   output logic             erro,
   output logic [CNT_W-1:0] drop_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned ENT_W = W + 2;

   logic [ENT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [OCC_W-1:0] r_occ;
   logic             r_erro;
   logic [CNT_W-1:0] r_drop;

   logic             w_accept;
   logic             w_illegal;
   logic             w_push;
   logic             w_pop;
   logic             w_nonempty;
   logic [ENT_W-1:0] w_head;
   logic [1:0]       w_head_sel;
   logic [W-1:0]     w_head_data;
   logic             w_v0;
   logic             w_v1;
   logic             w_v2;

   // Handshake and head decode, all derived from registered state.
   assign in_ready    = (r_occ != OCC_W'(DEPTH));
   assign w_accept    = in_valid && in_ready && !rst;
   assign w_illegal   = w_accept && (select_in == 2'b11);
   assign w_push      = w_accept && (select_in != 2'b11);
   assign w_nonempty  = (r_occ != '0);
   assign w_head      = r_mem[r_rptr];
   assign w_head_sel  = w_head[ENT_W-1 -: 2];
   assign w_head_data = w_head[W-1:0];

   assign w_v0  = w_nonempty && (w_head_sel == 2'd0);
   assign w_v1  = w_nonempty && (w_head_sel == 2'd1);
   assign w_v2  = w_nonempty && (w_head_sel == 2'd2);
   assign w_pop = (w_v0 && ready0) || (w_v1 && ready1) || (w_v2 && ready2);

   assign valid0 = w_v0;
   assign valid1 = w_v1;
   assign valid2 = w_v2;
   assign saida0 = w_v0 ? w_head_data : '0;
   assign saida1 = w_v1 ? w_head_data : '0;
   assign saida2 = w_v2 ? w_head_data : '0;

   assign erro       = r_erro;
   assign drop_count = r_drop;

   // Storage array carries no reset; entries are only visible while occupied.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {select_in, entrada};
      end
   end

   // Pointers, occupancy and the illegal-select bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
         r_erro <= 1'b0;
         r_drop <= '0;
      end else begin
         r_erro <= w_illegal;
         if (w_illegal && (r_drop != {CNT_W{1'b1}})) begin
            r_drop <= r_drop + CNT_W'(1);
         end
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: doc/demux3_buffered.md
Name: demux3_buffered

Overview:
- Inverse of the 3-way result select in the processor datapath.
- Accepts one W-bit word per cycle plus a 2-bit destination select.
- Buffers accepted words in a small in-order FIFO.
- Delivers each word to exactly one of three consumers over per-destination valid/ready handshakes.
- Sits between a producing stage (e.g. ALU result) and three consuming stages (e.g. register write-back, memory store path, I/O).

Parameters:
W, 32, data word width.
DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, 8, width of the illegal-select drop counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  producer has a word on entrada.
in_ready  output  1  block can accept a word this cycle.
select_in  input  2  destination: 2'b00 -> 0, 2'b01 -> 1, 2'b10 -> 2, 2'b11 illegal.
entrada  input  W  data word.
valid0/valid1/valid2  output  1 each  head word available for that destination.
ready0/ready1/ready2  input  1 each  that destination consumes this cycle.
saida0/saida1/saida2  output  W each  data to that destination.
erro  output  1  one-cycle pulse, registered, after an illegal-select word is accepted.
drop_count  output  CNT_W  number of illegal-select words dropped; saturating.

Behaviour:
- Reset (rst high at a clock edge):
  - Pointers and occupancy cleared; FIFO contents discarded.
  - erro=0, drop_count=0.
  - in_ready=1 from the next cycle.
  - All validK=0 and saidaK=0.
  - Reset has priority over any simultaneous push or pop; a word presented in the reset cycle is not accepted.
- Storage:
  - FIFO of DEPTH entries, each holding {sel[1:0], data[W-1:0]}.
  - Write and read pointers of log2(DEPTH) bits wrap modulo DEPTH.
  - Occupancy counter of log2(DEPTH)+1 bits.
- Input handshake:
  - in_ready = (occupancy != DEPTH), from registers only; it does not depend on in_valid or readyK.
  - Accept occurs when in_valid && in_ready at an edge.
- Illegal select (select_in == 2'b11) on an accepted word:
  - Word is not written to the FIFO.
  - erro=1 for exactly the next cycle.
  - drop_count increments, holding at 2^CNT_W-1.
  - in_ready behaves normally.
- Output side, first-word-fall-through from registers:
  - validK = (occupancy != 0) && (head.sel == K).
  - saidaK = head.data when validK, else 0.
  - At most one validK is high in any cycle.
- Pop occurs when validK && readyK; readyK is ignored when validK=0.
- Strict in-order delivery:
  - A stalled destination blocks words queued for other destinations (head-of-line blocking is required behaviour, not a defect).
- Latency:
  - A word accepted at edge N appears on its saidaK/validK in the cycle after edge N, when the FIFO was empty.
  - Otherwise it appears after all older words have popped.
- Simultaneous push and pop in one cycle:
  - Occupancy unchanged; both pointers advance.
  - When full, no push can occur (in_ready=0) even if a pop happens that cycle; no same-cycle pass-through.
- Empty FIFO: all validK=0; an empty pop is impossible by construction.
- Full FIFO: in_ready=0; in_valid held high is ignored without corrupting state.
- Wrap-around: pointer rollover from DEPTH-1 to 0 preserves order and data.
- Reset mid-transfer: queued words are lost; nothing is delivered after reset until new words are accepted.

Test Plan:
1. Single-word routing: reset, push 0xAAAA0001 sel=01 with ready1=1 -> next cycle valid1=1, saida1=0xAAAA0001, valid0=valid2=0; following cycle all valid=0.
2. Fill and stall: all readyK=0, push sel=00 data 1,2,3,4,5 back-to-back -> in_ready=0 after the 4th accept; 5th word not accepted. Then ready0=1 -> saida0 delivers 1,2,3,4 on consecutive cycles, and in_ready returns to 1 one cycle after the first pop.
3. Head-of-line blocking: push A sel=10, B sel=00; ready2=0, ready0=1 -> valid0 stays 0 while A is at head. Set ready2=1 -> A pops, then B appears on saida0 the next cycle.
4. Illegal select: push sel=11 data 0xDEAD -> FIFO occupancy unchanged, erro high exactly one cycle, drop_count=1. 300 illegal pushes with CNT_W=8 -> drop_count=255.
5. Wrap and concurrency: continuous push with rotating sel 00/01/10 and all ready=1 for 20 words -> each word emerges on the correct port in order, occupancy steady at 1, no drops, pointers wrap several times.
6. Reset mid-operation: 3 words queued, rst for one cycle while in_valid=1 -> all validK=0 next cycle, erro=0, drop_count=0, pushed word discarded, in_ready=1.
